// File: rtl/muldiv_pkg.sv
// Shared types and sizing for the iterative MIPS multiply/divide engine.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  localparam int MD_WIDTH = 32;
  localparam int CNT_W    = $clog2(MD_WIDTH);

endpackage

// File: rtl/muldiv_sign_fix.sv
// Sign/magnitude pre-conditioning of rs/rt operands and post-negation of the
// unsigned HI/LO result. Purely combinational.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_mag_a,
  output logic [WIDTH-1:0] o_mag_b,
  output logic             o_sign_a,
  output logic             o_sign_b,
  input  logic             i_is_mul,
  input  logic             i_neg_lo,
  input  logic             i_neg_hi,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  always_comb begin
    o_sign_a = i_signed & i_a[WIDTH-1];
    o_sign_b = i_signed & i_b[WIDTH-1];
    o_mag_a  = o_sign_a ? -i_a : i_a;
    o_mag_b  = o_sign_b ? -i_b : i_b;
  end

  // Multiply negates the full double-width product; divide negates quotient
  // and remainder independently.
  always_comb begin
    o_hi = i_hi;
    o_lo = i_lo;
    if (i_is_mul) begin
      if (i_neg_lo) {o_hi, o_lo} = -{i_hi, i_lo};
    end else begin
      if (i_neg_lo) o_lo = -i_lo;
      if (i_neg_hi) o_hi = -i_hi;
    end
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU engine feeding the HI/LO register stage.
// Optional MULDIV_EARLY_OUT_EN skips the iteration for zero operands.
//
// state  | meaning
// S_IDLE | waiting for start; operands latched on acceptance
// S_RUN  | WIDTH shift-add / restoring-divide steps
// S_FIX  | sign correction, hi_out/lo_out written
// S_DONE | done pulse, back to idle
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  state_e           r_state, w_next;
  op_e              r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_opnd, r_hi_out, r_lo_out;
  logic             r_sign1, r_sign2, r_dz;

  logic [WIDTH-1:0] w_mag1, w_mag2, w_fix_hi, w_fix_lo;
  logic             w_s1, w_s2, w_in_div, w_r_div, w_accept, w_early, w_borrow;
  logic [WIDTH:0]   w_mul_sum, w_div_shift, w_div_diff;

  assign w_in_div = op[1];
  assign w_r_div  = (r_op == OP_DIV) || (r_op == OP_DIVU);
  assign w_accept = (r_state == S_IDLE) && start && !flush;

`ifdef MULDIV_EARLY_OUT_EN
  assign w_early = (in_2 == '0) || (!w_in_div && (in_1 == '0));
`else
  assign w_early = 1'b0;
`endif

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .i_signed (~op[0]),
    .i_a      (in_1),
    .i_b      (in_2),
    .o_mag_a  (w_mag1),
    .o_mag_b  (w_mag2),
    .o_sign_a (w_s1),
    .o_sign_b (w_s2),
    .i_is_mul (!w_r_div),
    .i_neg_lo (r_sign1 ^ r_sign2),
    .i_neg_hi (r_sign1),
    .i_hi     (r_hi),
    .i_lo     (r_lo),
    .o_hi     (w_fix_hi),
    .o_lo     (w_fix_lo)
  );

  assign w_mul_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : '0)};
  assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opnd};
  assign w_borrow    = w_div_diff[WIDTH];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_early ? S_FIX : S_RUN;
      S_RUN: begin
        if (flush) w_next = S_IDLE;
        else if (r_cnt == CNT_W'(WIDTH - 1)) w_next = S_FIX;
      end
      S_FIX:   w_next = flush ? S_IDLE : S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_op     <= OP_MULT;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_sign1  <= 1'b0;
      r_sign2  <= 1'b0;
      r_dz     <= 1'b0;
      r_hi_out <= '0;
      r_lo_out <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op    <= op_e'(op);
          r_sign1 <= w_s1;
          r_sign2 <= w_s2;
          r_cnt   <= '0;
          r_dz    <= w_in_div && (in_2 == '0);
          // Early-out preloads the magnitude result the iteration would reach.
          if (w_early) begin
            r_hi <= w_in_div ? w_mag1 : '0;
            r_lo <= w_in_div ? '1 : '0;
          end else begin
            r_hi   <= '0;
            r_opnd <= w_in_div ? w_mag2 : w_mag1;
            r_lo   <= w_in_div ? w_mag1 : w_mag2;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_r_div) begin
            r_hi <= w_borrow ? w_div_shift[WIDTH-1:0] : w_div_diff[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], ~w_borrow};
          end else begin
            r_hi <= w_mul_sum[WIDTH:1];
            r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
          end
        end
        S_FIX: if (!flush) begin
          r_hi_out <= w_fix_hi;
          r_lo_out <= r_dz ? '1 : w_fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign hi_out = r_hi_out;
  assign lo_out = r_lo_out;

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench for muldiv_iter: directed vectors with hand-computed HI/LO
// and done latency, plus start-while-busy, flush and async reset scenarios.
module tb_muldiv_iter;

  logic        clk, reset, start, flush;
  logic [1:0]  op;
  logic [31:0] in_1, in_2, hi_out, lo_out;
  logic        busy, done;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          edg;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          edge_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] last_hi = 32'h0;
  logic [31:0] last_lo = 32'h0;

  muldiv_iter dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .flush  (flush),
    .op     (op),
    .in_1   (in_1),
    .in_2   (in_2),
    .busy   (busy),
    .done   (done),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (b == 32'h0 || (!o[1] && a == 32'h0)) return 2;
`endif
    return 34;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at edge %0d expected no done", edge_cnt);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi_out", hi_out, e.hi);
        chk("lo_out", lo_out, e.lo);
        chk("done_edge", edge_cnt, e.edg);
      end
    end
  end

  // Drives one request; returns at the negedge after the acceptance edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input bit push);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; in_1 = a; in_2 = b;
    if (push) begin
      e.hi = eh; e.lo = el; e.edg = edge_cnt + lat(o, a, b);
      sb.push_back(e);
      last_hi = eh; last_lo = el;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 60) begin
      @(negedge clk);
      i++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[$] = '{
    '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1},
    '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
    '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
    '{2'b11, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF},
    '{2'b10, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF},
    '{2'b01, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000},
    '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E},
    '{2'b00, 32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6},
    '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
    '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000},
    '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    reset = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; in_1 = '0; in_2 = '0;
    #3;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_hi", hi_out, 32'h0);
    chk("rst_lo", lo_out, 32'h0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);

    // MULTU max*max with busy profile: busy after edges 1..34, low after 35.
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1);
    chk("busy_edge1", {31'h0, busy}, 32'h1);
    repeat (33) @(negedge clk);
    chk("busy_edge34", {31'h0, busy}, 32'h1);
    chk("done_edge34", {31'h0, done}, 32'h1);
    @(negedge clk);
    chk("busy_edge35", {31'h0, busy}, 32'h0);
    chk("done_edge35", {31'h0, done}, 32'h0);
    drain();

    foreach (vecs[i]) begin
      issue(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b1);
      drain();
    end

    // Start while busy: second request at edge 10 must be ignored.
    d0 = done_cnt;
    issue(2'b01, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C, 1'b1);
    repeat (8) @(negedge clk);
    start = 1'b1; op = 2'b11; in_1 = 32'h9; in_2 = 32'h3;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (40) @(negedge clk);
    chk("busy_start_dones", done_cnt - d0, 32'h1);

    // Flush mid-run: back to idle, no done, outputs keep the prior result.
    issue(2'b01, 32'h00000005, 32'h00000005, 32'h0, 32'h0, 1'b0);
    repeat (13) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'h0, busy}, 32'h0);
    repeat (40) @(negedge clk);
    chk("flush_hi", hi_out, last_hi);
    chk("flush_lo", lo_out, last_lo);

    // Flush together with start in idle: request dropped.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b01; in_1 = 32'h2; in_2 = 32'h2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {31'h0, busy}, 32'h0);
    repeat (40) @(negedge clk);

    // Asynchronous reset mid-operation clears outputs before the next edge.
    issue(2'b11, 32'h000003E8, 32'h00000003, 32'h0, 32'h0, 1'b0);
    repeat (18) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_done", {31'h0, done}, 32'h0);
    chk("arst_hi", hi_out, 32'h0);
    chk("arst_lo", lo_out, 32'h0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    issue(2'b11, 32'h000003E8, 32'h00000003, 32'h00000001, 32'h0000014D, 1'b1);
    drain();
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
